// File: rtl/fb_scan_reader_pkg.sv
// Shared constants and types for the framebuffer scan-out read path.
package fb_scan_reader_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned SCALE_SHIFT = 2;
  localparam int unsigned FB_W        = 160;
  localparam int unsigned FB_H        = 120;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned DATA_W      = 24;
  localparam int unsigned RD_LAT_DEF  = 2;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned CHAN_W      = 8;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Pixel field slices: {R[23:16], G[15:8], B[7:0]}
  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/fb_scan_reader_if.sv
// Raster, memory-read, swap-handshake and pixel-out signals of the scan reader.
interface fb_scan_reader_if;
  import fb_scan_reader_pkg::*;

  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic               vga_active;
  logic               vga_hs_in;
  logic               vga_vs_in;
  logic               swap_req;
  logic               swap_ack;
  logic               front_sel;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic [CHAN_W-1:0]  pix_r;
  logic [CHAN_W-1:0]  pix_g;
  logic [CHAN_W-1:0]  pix_b;
  logic               hs_out;
  logic               vs_out;
  logic               blank_n_out;

  modport master (
    output vga_x, vga_y, vga_active, vga_hs_in, vga_vs_in, swap_req, rd_data,
    input  swap_ack, front_sel, rd_addr, pix_r, pix_g, pix_b, hs_out, vs_out, blank_n_out
  );

  modport slave (
    input  vga_x, vga_y, vga_active, vga_hs_in, vga_vs_in, swap_req, rd_data,
    output swap_ack, front_sel, rd_addr, pix_r, pix_g, pix_b, hs_out, vs_out, blank_n_out
  );

endinterface

// File: rtl/fb_scan_reader_sync_delay_line.sv
// Parameterised shift register; exposes the last stage and the one before it.
module sync_delay_line #(
  parameter int unsigned      DEPTH   = 4,
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_pre
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_delay_line needs DEPTH >= 2");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q     = stage_q[DEPTH-1];
  assign q_pre = stage_q[DEPTH-2];

endmodule

// File: rtl/fb_scan_reader.sv
// Front-bank read path: raster -> framebuffer address, sync/blank realignment,
// and the vsync-boundary bank-swap handshake.
module fb_scan_reader
  import fb_scan_reader_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input logic             clk,
  input logic             rst,
  fb_scan_reader_if.slave bus
);

  localparam int unsigned LAT = 1 + RD_LAT + 1;

  if (FB_W != (H_ACTIVE >> SCALE_SHIFT) || FB_H != (V_ACTIVE >> SCALE_SHIFT)) begin : g_bad_geom
    $error("framebuffer geometry does not match raster downscale");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("RD_LAT must be in 1..4");
  end

  // Address generation; FB_W = 160 = 128 + 32, so fy*FB_W is two shifts and an add.
  logic              in_view_c;
  logic [ADDR_W-1:0] fx_c;
  logic [ADDR_W-1:0] fy_c;
  logic [ADDR_W-1:0] addr_c;
  logic [ADDR_W-1:0] rd_addr_q;

  always_comb begin
    in_view_c = bus.vga_active
             && (bus.vga_x < COORD_W'(H_ACTIVE))
             && (bus.vga_y < COORD_W'(V_ACTIVE));
    fx_c      = ADDR_W'(bus.vga_x >> SCALE_SHIFT);
    fy_c      = ADDR_W'(bus.vga_y >> SCALE_SHIFT);
    addr_c    = in_view_c ? ((fy_c << 7) + (fy_c << 5) + fx_c) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_addr_q <= '0;
    else      rd_addr_q <= addr_c;
  end

  // {hs, vs, visible}; the pre-tap gates the pixel register one stage before the outputs.
  logic [2:0] dly_q;
  logic [2:0] dly_pre;

  sync_delay_line #(
    .DEPTH   (LAT),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk   (clk),
    .rst   (rst),
    .d     ({bus.vga_hs_in, bus.vga_vs_in, in_view_c}),
    .q     (dly_q),
    .q_pre (dly_pre)
  );

  pixel_t mem_pix_c;
  pixel_t pix_q;

  assign mem_pix_c = pixel_t'(bus.rd_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_q <= '0;
    else      pix_q <= dly_pre[0] ? mem_pix_c : '0;
  end

  // Swap handshake: request edge arms, vsync falling edge commits.
  swap_state_e state_q, state_nxt;
  logic        req_q;
  logic        vs_q;
  logic        front_q, front_nxt;
  logic        ack_q, ack_nxt;
  logic        req_edge_c;
  logic        vs_fall_c;

  assign req_edge_c = bus.swap_req & ~req_q;
  assign vs_fall_c  = vs_q & ~bus.vga_vs_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SWAP_IDLE;
      req_q   <= 1'b0;
      vs_q    <= 1'b1;
      front_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      req_q   <= bus.swap_req;
      vs_q    <= bus.vga_vs_in;
      front_q <= front_nxt;
      ack_q   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    front_nxt = front_q;
    ack_nxt   = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (req_edge_c) state_nxt = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (vs_fall_c) begin
          state_nxt = SWAP_IDLE;
          front_nxt = ~front_q;
          ack_nxt   = 1'b1;
        end
      end
    endcase
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.pix_r       = pix_q.r;
  assign bus.pix_g       = pix_q.g;
  assign bus.pix_b       = pix_q.b;
  assign bus.hs_out      = dly_q[2];
  assign bus.vs_out      = dly_q[1];
  assign bus.blank_n_out = dly_q[0];
  assign bus.front_sel   = front_q;
  assign bus.swap_ack    = ack_q;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed self-checking bench for fb_scan_reader with a 2-cycle memory model.
module tb_fb_scan_reader;
  import fb_scan_reader_pkg::*;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fb_scan_reader_if bus ();

  fb_scan_reader #(.RD_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: data appears two clocks after the address
  logic [DATA_W-1:0] mem_p0 = '0;
  logic [DATA_W-1:0] mem_p1 = '0;

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(162)) return 24'hFF8000;
    return {8'h11, 1'b0, a};
  endfunction

  always @(posedge clk) begin
    mem_p0 <= mem_f(bus.rd_addr);
    mem_p1 <= mem_p0;
  end
  assign bus.rd_data = mem_p1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic act, input logic hs, input logic vs);
    bus.vga_x      = COORD_W'(x);
    bus.vga_y      = COORD_W'(y);
    bus.vga_active = act;
    bus.vga_hs_in  = hs;
    bus.vga_vs_in  = vs;
  endtask

  task automatic test_reset;
    drive(100, 50, 1'b1, 1'b0, 1'b1);
    tick(6);
    rst = 1'b0;
    #1;
    n_tests++; if (bus.rd_addr !== '0)      begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.rd_addr); end
    n_tests++; if ({bus.pix_r, bus.pix_g, bus.pix_b} !== 24'h0) begin n_fail++; $display("FAIL rst_pix: got %h want 000000", {bus.pix_r, bus.pix_g, bus.pix_b}); end
    n_tests++; if (bus.hs_out !== 1'b1)     begin n_fail++; $display("FAIL rst_hs: got %b want 1", bus.hs_out); end
    n_tests++; if (bus.vs_out !== 1'b1)     begin n_fail++; $display("FAIL rst_vs: got %b want 1", bus.vs_out); end
    n_tests++; if (bus.blank_n_out !== 1'b0) begin n_fail++; $display("FAIL rst_blank: got %b want 0", bus.blank_n_out); end
    n_tests++; if (bus.front_sel !== 1'b0)  begin n_fail++; $display("FAIL rst_front: got %b want 0", bus.front_sel); end
    n_tests++; if (bus.swap_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus.swap_ack); end
    drive(8, 4, 1'b1, 1'b0, 1'b1);
    tick(1);
    rst = 1'b1;
    tick(3);
    n_tests++; if (bus.blank_n_out !== 1'b0 || bus.hs_out !== 1'b1) begin
      n_fail++; $display("FAIL rel_early: blank=%b hs=%b want blank=0 hs=1", bus.blank_n_out, bus.hs_out);
    end
    tick(1);
    n_tests++; if (bus.blank_n_out !== 1'b1 || bus.hs_out !== 1'b0) begin
      n_fail++; $display("FAIL rel_first: blank=%b hs=%b want blank=1 hs=0", bus.blank_n_out, bus.hs_out);
    end
    n_tests++; if ({bus.pix_r, bus.pix_g, bus.pix_b} !== 24'hFF8000) begin
      n_fail++; $display("FAIL rel_pix: got %h want ff8000", {bus.pix_r, bus.pix_g, bus.pix_b});
    end
  endtask

  task automatic test_addr_map;
    int               vx [5] = '{8, 13, 0, 636, 639};
    int               vy [5] = '{4, 9, 0, 2, 479};
    logic             va [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int               ea [5] = '{162, 323, 0, 159, 19199};
    logic [DATA_W-1:0] ep [5] = '{24'hFF8000, 24'h110143, 24'h110000, 24'h11009F, 24'h114AFF};
    for (int i = 0; i < 5; i++) begin
      drive(vx[i], vy[i], va[i], 1'b1, 1'b1);
      tick(1);
      n_tests++; if (bus.rd_addr !== ADDR_W'(ea[i])) begin
        n_fail++; $display("FAIL addr_%0d_%0d: got %0d want %0d", vx[i], vy[i], bus.rd_addr, ea[i]);
      end
      tick(3);
      n_tests++; if ({bus.pix_r, bus.pix_g, bus.pix_b} !== ep[i] || bus.blank_n_out !== 1'b1) begin
        n_fail++; $display("FAIL pix_%0d_%0d: got %h blank=%b want %h blank=1", vx[i], vy[i],
                           {bus.pix_r, bus.pix_g, bus.pix_b}, bus.blank_n_out, ep[i]);
      end
    end
  endtask

  task automatic test_blanking;
    int   vx [4] = '{700, 10, 10, 640};
    int   vy [4] = '{10, 10, 480, 0};
    logic va [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(vx[i], vy[i], va[i], 1'b1, 1'b1);
      tick(1);
      n_tests++; if (bus.rd_addr !== '0) begin
        n_fail++; $display("FAIL blank_addr_%0d: got %0d want 0", i, bus.rd_addr);
      end
      tick(3);
      n_tests++; if ({bus.pix_r, bus.pix_g, bus.pix_b} !== 24'h0 || bus.blank_n_out !== 1'b0) begin
        n_fail++; $display("FAIL blank_pix_%0d: got %h blank=%b want 000000 blank=0", i,
                           {bus.pix_r, bus.pix_g, bus.pix_b}, bus.blank_n_out);
      end
    end
  endtask

  task automatic test_swap_single;
    int acks = 0;
    bus.vga_vs_in = 1'b1;
    tick(2);
    bus.swap_req = 1'b1;
    tick(1);
    bus.swap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acks += int'(bus.swap_ack);
    end
    n_tests++; if (acks != 0 || bus.front_sel !== 1'b0) begin
      n_fail++; $display("FAIL swap_wait: acks=%0d front=%b want acks=0 front=0", acks, bus.front_sel);
    end
    bus.vga_vs_in = 1'b0;
    tick(1);
    n_tests++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b1) begin
      n_fail++; $display("FAIL swap_commit: front=%b ack=%b want front=1 ack=1", bus.front_sel, bus.swap_ack);
    end
    tick(1);
    n_tests++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL swap_ack_len: front=%b ack=%b want front=1 ack=0", bus.front_sel, bus.swap_ack);
    end
  endtask

  task automatic test_coalesce;
    int acks = 0;
    bus.vga_vs_in = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      bus.swap_req = 1'b1;
      tick(1);
      bus.swap_req = 1'b0;
      tick(2);
    end
    bus.vga_vs_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      acks += int'(bus.swap_ack);
    end
    n_tests++; if (acks != 1 || bus.front_sel !== 1'b0) begin
      n_fail++; $display("FAIL coalesce: acks=%0d front=%b want acks=1 front=0", acks, bus.front_sel);
    end
    acks = 0;
    bus.vga_vs_in = 1'b1;
    tick(5);
    bus.vga_vs_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      acks += int'(bus.swap_ack);
    end
    n_tests++; if (acks != 0 || bus.front_sel !== 1'b0) begin
      n_fail++; $display("FAIL no_req_vs: acks=%0d front=%b want acks=0 front=0", acks, bus.front_sel);
    end
  endtask

  task automatic test_coincident;
    bus.vga_vs_in = 1'b1;
    tick(3);
    bus.swap_req  = 1'b1;
    bus.vga_vs_in = 1'b0;
    tick(1);
    n_tests++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL coinc_same: front=%b ack=%b want front=0 ack=0", bus.front_sel, bus.swap_ack);
    end
    bus.swap_req  = 1'b0;
    bus.vga_vs_in = 1'b1;
    tick(4);
    n_tests++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL coinc_hold: front=%b ack=%b want front=0 ack=0", bus.front_sel, bus.swap_ack);
    end
    bus.vga_vs_in = 1'b0;
    tick(1);
    n_tests++; if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b1) begin
      n_fail++; $display("FAIL coinc_next: front=%b ack=%b want front=1 ack=1", bus.front_sel, bus.swap_ack);
    end
  endtask

  task automatic test_reset_pending;
    int acks = 0;
    bus.vga_vs_in = 1'b1;
    tick(2);
    bus.swap_req = 1'b1;
    tick(1);
    bus.swap_req = 1'b0;
    tick(2);
    rst = 1'b0;
    #1;
    n_tests++; if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL rstp_now: front=%b ack=%b want front=0 ack=0", bus.front_sel, bus.swap_ack);
    end
    tick(1);
    rst = 1'b1;
    tick(2);
    bus.vga_vs_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      acks += int'(bus.swap_ack);
    end
    n_tests++; if (acks != 0 || bus.front_sel !== 1'b0) begin
      n_fail++; $display("FAIL rstp_drop: acks=%0d front=%b want acks=0 front=0", acks, bus.front_sel);
    end
  endtask

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              vis;
    logic [DATA_W-1:0] pix;
  } exp_t;

  // Lines 476..515 of the 800x525 raster: visible tail, vertical blanking and vsync.
  task automatic test_frame_sweep;
    exp_t q[$];
    exp_t e;
    exp_t n;
    int   bad_hs = 0, bad_vs = 0, bad_bl = 0, bad_px = 0, checked = 0;
    bus.swap_req = 1'b0;
    for (int y = 476; y < 516; y++) begin
      for (int x = 0; x < 800; x++) begin
        if (q.size() == LAT) begin
          e = q.pop_front();
          checked++;
          if (bus.hs_out !== e.hs) bad_hs++;
          if (bus.vs_out !== e.vs) bad_vs++;
          if (bus.blank_n_out !== e.vis) bad_bl++;
          if ({bus.pix_r, bus.pix_g, bus.pix_b} !== e.pix) bad_px++;
        end
        n.hs  = !(x >= 656 && x < 752);
        n.vs  = !(y >= 490 && y < 492);
        n.vis = (x < 640) && (y < 480);
        n.pix = n.vis ? mem_f(ADDR_W'((y / 4) * 160 + x / 4)) : '0;
        drive(x, y, n.vis, n.hs, n.vs);
        q.push_back(n);
        tick(1);
      end
    end
    n_tests++; if (bad_hs != 0) begin n_fail++; $display("FAIL sweep_hs: %0d of %0d cycles differ, want 0", bad_hs, checked); end
    n_tests++; if (bad_vs != 0) begin n_fail++; $display("FAIL sweep_vs: %0d of %0d cycles differ, want 0", bad_vs, checked); end
    n_tests++; if (bad_bl != 0) begin n_fail++; $display("FAIL sweep_blank: %0d of %0d cycles differ, want 0", bad_bl, checked); end
    n_tests++; if (bad_px != 0) begin n_fail++; $display("FAIL sweep_pix: %0d of %0d cycles differ, want 0", bad_px, checked); end
  endtask

  initial begin
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    bus.swap_req = 1'b0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    test_reset();
    test_addr_map();
    test_blanking();
    test_swap_single();
    test_coalesce();
    test_coincident();
    test_reset_pending();
    test_frame_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
